// File: rtl/slurm16_mem_arb_pkg.sv
// Shared state encoding and width helper for the slurm16 memory arbiter.
package slurm16_mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    // Bits needed to index 'value' items; never less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/slurm16_rr_picker.sv
// Rotating priority encoder: grants the first request at or after ptr, wrapping modulo N_REQ.
module slurm16_rr_picker #(
    parameter int unsigned N_REQ    = 3,
    parameter int unsigned PTR_BITS = 2
) (
    input  logic [N_REQ-1:0]    req,
    input  logic [PTR_BITS-1:0] ptr,
    output logic [PTR_BITS-1:0] grant,
    output logic                any
);

    localparam logic [PTR_BITS:0] N_WIDE = (PTR_BITS + 1)'(N_REQ);

    always_comb begin
        logic [PTR_BITS:0] idx;
        grant = '0;
        idx   = '0;
        // Scan from the far end so the request nearest ptr is written last and wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (PTR_BITS + 1)'(i);
            if (idx >= N_WIDE) idx = idx - N_WIDE;
            if (req[idx[PTR_BITS-1:0]]) grant = idx[PTR_BITS-1:0];
        end
    end

    assign any = |req;

endmodule

// File: rtl/slurm16_memory_arbiter.sv
// Round-robin arbiter with burst limit sharing one 1-cycle memory among N masters (0 = CPU).
// Define ARBITER_CPU_PRIORITY_EN to let master 0 win arbitration and preempt other owners.
module slurm16_memory_arbiter
    import slurm16_mem_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS    = 3,
    parameter int unsigned BITS         = 16,
    parameter int unsigned ADDRESS_BITS = 16,
    parameter int unsigned MAX_BURST    = 8
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [N_MASTERS*ADDRESS_BITS-1:0] m_address,
    input  logic [N_MASTERS*BITS-1:0]         m_wdata,
    input  logic [N_MASTERS-1:0]              m_valid,
    input  logic [N_MASTERS-1:0]              m_wr,
    input  logic [2*N_MASTERS-1:0]            m_wr_mask,
    output logic [N_MASTERS-1:0]              m_ready,
    output logic [N_MASTERS-1:0]              m_rvalid,
    output logic [ADDRESS_BITS-1:0]           mem_address,
    output logic [BITS-1:0]                   mem_wdata,
    output logic                              mem_wr,
    output logic [1:0]                        mem_wr_mask
);

    localparam int unsigned OWNER_BITS = clog2(N_MASTERS);
    localparam int unsigned BURST_BITS = clog2(MAX_BURST);
    localparam logic [BURST_BITS-1:0] BURST_LAST  = BURST_BITS'(MAX_BURST - 1);
    localparam logic [OWNER_BITS-1:0] LAST_MASTER = OWNER_BITS'(N_MASTERS - 1);

    arb_state_e state_q, state_d;
    logic [OWNER_BITS-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d;
    logic [BURST_BITS-1:0] burst_cnt_q, burst_cnt_d;
    logic [N_MASTERS-1:0]  rvalid_q, rvalid_d;

    logic [N_MASTERS-1:0]    owner_onehot, pick_req;
    logic [OWNER_BITS-1:0]   owner_inc, pick_ptr, pick_grant, next_owner;
    logic [ADDRESS_BITS-1:0] sel_address;
    logic [BITS-1:0]         sel_wdata;
    logic [1:0]              sel_mask;
    logic sel_wr, pick_any, owned, owner_valid, accept, other, release_rr, preempt, cpu_first;

    always_comb begin
        owner_onehot = '0;
        sel_address  = '0;
        sel_wdata    = '0;
        sel_wr       = 1'b0;
        sel_mask     = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (owner_q == OWNER_BITS'(i)) begin
                owner_onehot[i] = 1'b1;
                sel_address     = m_address[i*ADDRESS_BITS +: ADDRESS_BITS];
                sel_wdata       = m_wdata[i*BITS +: BITS];
                sel_wr          = m_wr[i];
                sel_mask        = m_wr_mask[2*i +: 2];
            end
        end
    end

    assign owned       = (state_q == ARB_OWNED);
    assign owner_valid = |(m_valid & owner_onehot);
    assign accept      = owned & owner_valid;
    assign other       = |(m_valid & ~owner_onehot);
    assign owner_inc   = (owner_q == LAST_MASTER) ? '0 : owner_q + 1'b1;
    assign release_rr  = owned & (~owner_valid | (accept & (burst_cnt_q == BURST_LAST) & other));

    assign m_ready     = owned ? (m_valid & owner_onehot) : '0;
    assign mem_address = owned ? sel_address : '0;
    assign mem_wdata   = owned ? sel_wdata : '0;
    assign mem_wr      = accept & sel_wr;
    assign mem_wr_mask = mem_wr ? sel_mask : 2'b00;
    assign m_rvalid    = rvalid_q;

    // During handover the current owner is masked, so the scan starts at owner+1.
    assign pick_req = owned ? (m_valid & ~owner_onehot) : m_valid;
    assign pick_ptr = owned ? owner_inc : rr_ptr_q;

    slurm16_rr_picker #(
        .N_REQ    (N_MASTERS),
        .PTR_BITS (OWNER_BITS)
    ) u_picker (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .grant (pick_grant),
        .any   (pick_any)
    );

`ifdef ARBITER_CPU_PRIORITY_EN
    assign preempt   = owned && (owner_q != '0) && m_valid[0];
    // A CPU owner hitting its burst limit must still yield to the others.
    assign cpu_first = m_valid[0] && !(owned && (owner_q == '0));
`else
    assign preempt   = 1'b0;
    assign cpu_first = 1'b0;
`endif
    assign next_owner = cpu_first ? '0 : pick_grant;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        rvalid_d    = (accept && !sel_wr) ? owner_onehot : '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d     = ARB_OWNED;
                    owner_d     = next_owner;
                    burst_cnt_d = '0;
                end
            end
            ARB_OWNED: begin
                if (release_rr) rr_ptr_d = owner_inc;
                if (release_rr || preempt) begin
                    if (other) begin
                        owner_d     = next_owner;
                        burst_cnt_d = '0;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (accept && (burst_cnt_q != BURST_LAST)) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            rvalid_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid_q    <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_slurm16_memory_arbiter.sv
// Self-checking bench for slurm16_memory_arbiter: vector table, corner sequences, random vs model.
module tb_slurm16_memory_arbiter;

    localparam int NM   = 3;
    localparam int MAXB = 8;
`ifdef ARBITER_CPU_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic            CLK, RST;
    logic [NM*16-1:0] m_address, m_wdata;
    logic [NM-1:0]   m_valid, m_wr, m_ready, m_rvalid;
    logic [2*NM-1:0] m_wr_mask;
    logic [15:0]     mem_address, mem_wdata;
    logic            mem_wr;
    logic [1:0]      mem_wr_mask;

    logic [2:0]  valid, wr;
    logic [15:0] addr_a [NM];
    logic [15:0] data_a [NM];
    logic [1:0]  mask_a [NM];

    int total = 0;
    int bad   = 0;

    // Reference model state: owner -1 means nobody holds the bus.
    int         mo_owner, mo_rr, mo_cnt;
    logic [2:0] mo_rvalid, exp_ready;

    always_comb begin
        m_valid = valid;
        m_wr    = wr;
        for (int i = 0; i < NM; i++) begin
            m_address[i*16 +: 16] = addr_a[i];
            m_wdata[i*16 +: 16]   = data_a[i];
            m_wr_mask[i*2 +: 2]   = mask_a[i];
        end
    end

    slurm16_memory_arbiter #(
        .N_MASTERS    (NM),
        .BITS         (16),
        .ADDRESS_BITS (16),
        .MAX_BURST    (MAXB)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .m_address   (m_address),
        .m_wdata     (m_wdata),
        .m_valid     (m_valid),
        .m_wr        (m_wr),
        .m_wr_mask   (m_wr_mask),
        .m_ready     (m_ready),
        .m_rvalid    (m_rvalid),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_wr      (mem_wr),
        .mem_wr_mask (mem_wr_mask)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST   = 1'b1;
        valid = '0;
        wr    = '0;
        tick();
        tick();
        RST       = 1'b0;
        mo_owner  = -1;
        mo_rr     = 0;
        mo_cnt    = 0;
        mo_rvalid = '0;
    endtask

    function automatic int pick(input logic [2:0] req, input int start);
        for (int k = 0; k < NM; k++) begin
            int j;
            j = (start + k) % NM;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    // Compare outputs with the model for the current cycle, then advance the model one edge.
    task automatic model_step();
        logic [2:0]  rdy, others;
        logic        ewr;
        logic [1:0]  emask;
        logic [15:0] eaddr, edata;
        int o;
        bit acc, rel, pre;
        o = mo_owner;
        rdy = '0; ewr = 1'b0; emask = '0; eaddr = '0; edata = '0;
        if (o >= 0) begin
            eaddr = addr_a[o];
            edata = data_a[o];
            if (valid[o]) begin
                rdy[o] = 1'b1;
                ewr    = wr[o];
                if (wr[o]) emask = mask_a[o];
            end
        end
        chk("rnd ready", 32'(m_ready), 32'(rdy));
        chk("rnd rvalid", 32'(m_rvalid), 32'(mo_rvalid));
        chk("rnd mem_wr", 32'(mem_wr), 32'(ewr));
        chk("rnd mask", 32'(mem_wr_mask), 32'(emask));
        chk("rnd addr", 32'(mem_address), 32'(eaddr));
        chk("rnd wdata", 32'(mem_wdata), 32'(edata));
        exp_ready = rdy;
        if (o < 0) begin
            mo_rvalid = '0;
            if (valid != 0) begin
                mo_owner = (PRIO && valid[0]) ? 0 : pick(valid, mo_rr);
                mo_cnt   = 0;
            end
        end else begin
            acc       = valid[o];
            others    = valid;
            others[o] = 1'b0;
            rel       = !acc || (mo_cnt == MAXB - 1 && others != 0);
            pre       = PRIO && o != 0 && valid[0];
            mo_rvalid = (acc && !wr[o]) ? rdy : 3'b000;
            if (rel) mo_rr = (o + 1) % NM;
            if (rel || pre) begin
                if (others != 0) begin
                    mo_owner = (PRIO && valid[0] && o != 0) ? 0 : pick(others, (o + 1) % NM);
                    mo_cnt   = 0;
                end else begin
                    mo_owner = -1;
                end
            end else if (mo_cnt < MAXB - 1) begin
                mo_cnt++;
            end
        end
    endtask

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  wr;
        logic [2:0]  ready;
        logic [2:0]  rvalid;
        logic        mem_wr;
        logic [1:0]  mask;
        logic [15:0] addr;
        logic [15:0] wdata;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        int exp_i;
        logic [2:0] prev, ev;

        addr_a[0] = 16'h1234; data_a[0] = 16'hA0A0; mask_a[0] = 2'b11;
        addr_a[1] = 16'h0040; data_a[1] = 16'hBEEF; mask_a[1] = 2'b01;
        addr_a[2] = 16'h2000; data_a[2] = 16'hC2C2; mask_a[2] = 2'b11;

        vecs[0]  = '{3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 2'b00, 16'h0000, 16'h0000};
        vecs[1]  = '{3'b001, 3'b000, 3'b001, 3'b000, 1'b0, 2'b00, 16'h1234, 16'hA0A0};
        vecs[2]  = '{3'b010, 3'b010, 3'b000, 3'b001, 1'b0, 2'b00, 16'h1234, 16'hA0A0};
        vecs[3]  = '{3'b010, 3'b010, 3'b010, 3'b000, 1'b1, 2'b01, 16'h0040, 16'hBEEF};
        vecs[4]  = '{3'b100, 3'b000, 3'b000, 3'b000, 1'b0, 2'b00, 16'h0040, 16'hBEEF};
        vecs[5]  = '{3'b100, 3'b000, 3'b100, 3'b000, 1'b0, 2'b00, 16'h2000, 16'hC2C2};
        vecs[6]  = '{3'b000, 3'b000, 3'b000, 3'b100, 1'b0, 2'b00, 16'h2000, 16'hC2C2};
        vecs[7]  = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 2'b00, 16'h0000, 16'h0000};
        vecs[8]  = '{3'b110, 3'b000, 3'b000, 3'b000, 1'b0, 2'b00, 16'h0000, 16'h0000};
        vecs[9]  = '{3'b110, 3'b000, 3'b010, 3'b000, 1'b0, 2'b00, 16'h0040, 16'hBEEF};
        vecs[10] = '{3'b100, 3'b000, 3'b000, 3'b010, 1'b0, 2'b00, 16'h0040, 16'hBEEF};
        vecs[11] = '{3'b100, 3'b000, 3'b100, 3'b000, 1'b0, 2'b00, 16'h2000, 16'hC2C2};
        vecs[12] = '{3'b000, 3'b000, 3'b000, 3'b100, 1'b0, 2'b00, 16'h2000, 16'hC2C2};

        // Reset state, with every master requesting so outputs must be forced low.
        RST   = 1'b1;
        valid = 3'b111;
        wr    = 3'b111;
        #12;
        chk("reset ready", 32'(m_ready), 32'd0);
        chk("reset rvalid", 32'(m_rvalid), 32'd0);
        chk("reset mem_wr", 32'(mem_wr), 32'd0);
        chk("reset mask", 32'(mem_wr_mask), 32'd0);
        chk("reset addr", 32'(mem_address), 32'd0);
        chk("reset wdata", 32'(mem_wdata), 32'd0);

        // Vector table: CPU read, drop/raise handover, DMA write, idle and re-arbitration.
        do_reset();
        for (int r = 0; r < NV; r++) begin
            valid = vecs[r].valid;
            wr    = vecs[r].wr;
            @(negedge CLK);
            chk($sformatf("vec%0d ready", r), 32'(m_ready), 32'(vecs[r].ready));
            chk($sformatf("vec%0d rvalid", r), 32'(m_rvalid), 32'(vecs[r].rvalid));
            chk($sformatf("vec%0d mem_wr", r), 32'(mem_wr), 32'(vecs[r].mem_wr));
            chk($sformatf("vec%0d mask", r), 32'(mem_wr_mask), 32'(vecs[r].mask));
            chk($sformatf("vec%0d addr", r), 32'(mem_address), 32'(vecs[r].addr));
            chk($sformatf("vec%0d wdata", r), 32'(mem_wdata), 32'(vecs[r].wdata));
            tick();
        end

        // All masters streaming reads: 8-accept tenures rotating 0,1,2,0 after one arbitration cycle.
        do_reset();
        valid = 3'b111;
        wr    = 3'b000;
        prev  = '0;
        for (int k = 0; k < 57; k++) begin
            exp_i = (k == 0) ? -1 : ((k - 1) / MAXB) % NM;
            ev    = (exp_i < 0) ? 3'b000 : 3'(1 << exp_i);
            @(negedge CLK);
            chk($sformatf("burst k%0d ready", k), 32'(m_ready), 32'(ev));
            chk($sformatf("burst k%0d rvalid", k), 32'(m_rvalid), 32'(prev));
            prev = ev;
            tick();
        end

        // Master 2 mid-burst when the CPU raises its request on the 4th accept (cnt=3).
        do_reset();
        valid = 3'b100;
        for (int k = 0; k < 11; k++) begin
            if (k == 4) valid = 3'b101;
            if (k == 0) ev = 3'b000;
            else if (k <= (PRIO ? 4 : 8)) ev = 3'b100;
            else ev = 3'b001;
            @(negedge CLK);
            chk($sformatf("cpu k%0d ready", k), 32'(m_ready), 32'(ev));
            tick();
        end

        // Asynchronous reset in the middle of an accepted write, with a read completion pending.
        do_reset();
        valid = 3'b001; wr = 3'b000;
        tick();
        tick();
        valid = 3'b010;
        tick();
        @(negedge CLK);
        chk("rst pre ready", 32'(m_ready), 32'(3'b010));
        tick();
        wr = 3'b010;
        @(negedge CLK);
        chk("rst pre mem_wr", 32'(mem_wr), 32'd1);
        chk("rst pre rvalid", 32'(m_rvalid), 32'(3'b010));
        #2;
        RST = 1'b1;
        #1;
        chk("rst async ready", 32'(m_ready), 32'd0);
        chk("rst async mem_wr", 32'(mem_wr), 32'd0);
        chk("rst async rvalid", 32'(m_rvalid), 32'd0);
        tick();
        RST   = 1'b0;
        valid = 3'b101;
        wr    = 3'b000;
        @(negedge CLK);
        chk("rst idle ready", 32'(m_ready), 32'd0);
        chk("rst idle addr", 32'(mem_address), 32'd0);
        tick();
        @(negedge CLK);
        chk("rst rr ready", 32'(m_ready), 32'(3'b001));
        chk("rst rr addr", 32'(mem_address), 32'(16'h1234));
        tick();

        // Random masters that hold each request until it is accepted.
        do_reset();
        begin
            logic [2:0] pend;
            pend = '0;
            for (int c = 0; c < 1500; c++) begin
                for (int i = 0; i < NM; i++) begin
                    if (!pend[i] && $urandom_range(0, 99) < 45) begin
                        pend[i]   = 1'b1;
                        addr_a[i] = 16'($urandom);
                        data_a[i] = 16'($urandom);
                        mask_a[i] = 2'($urandom);
                        wr[i]     = 1'($urandom);
                    end
                end
                valid = pend;
                @(negedge CLK);
                model_step();
                pend = pend & ~exp_ready;
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
